// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdWgt,
    StLdIfm,
    StCompute,
    StDrain,
    StFin
  } ctrl_state_t;

  localparam int unsigned DefaultPeLat = 2;

  // Number of valid output positions of a K-wide kernel over a row of length len.
  function automatic int unsigned n_out(input int unsigned len, input int unsigned k);
    return len - k + 1;
  endfunction

endpackage

// File: rtl/conv_seq_ctrl_if.sv
// Buffer-side and accelerator-side signals of the convolution sequencer.
interface conv_seq_ctrl_if #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned IFM_WIDTH    = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned INDEX_WIDTH  = 4
) ();

  logic [INDEX_WIDTH-1:0]              wgt_addr;
  logic                                wgt_re;
  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] wgt_rdata;
  logic [INDEX_WIDTH-1:0]              ifm_addr;
  logic                                ifm_re;
  logic [IFM_WIDTH-1:0]                ifm_rdata;
  logic                                set_wgt;
  logic                                set_ifm;
  logic                                wr_en;
  logic                                rd_en;
  logic                                set_reg;
  logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] wgt;
  logic [IFM_WIDTH-1:0]                ifm;
  logic [DATA_WIDTH-1:0]               data_output;

  modport master (
    output wgt_addr, wgt_re, ifm_addr, ifm_re,
    output set_wgt, set_ifm, wr_en, rd_en, set_reg, wgt, ifm,
    input  wgt_rdata, ifm_rdata, data_output
  );

  modport slave (
    input  wgt_addr, wgt_re, ifm_addr, ifm_re,
    input  set_wgt, set_ifm, wr_en, rd_en, set_reg, wgt, ifm,
    output wgt_rdata, ifm_rdata, data_output
  );

endinterface

// File: rtl/seq_cnt.sv
// Loadable down-counter with terminal-count flag; stops at zero.
module seq_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == '0);

endmodule

// File: rtl/conv_seq_ctrl.sv
// Job sequencer: loads one kernel and one IFM row into the accelerator, runs it, captures results.
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned IFM_WIDTH    = 8,
  parameter int unsigned KERNEL_SIZE  = 3,
  parameter int unsigned FIFO_SIZE    = 10,
  parameter int unsigned INDEX_WIDTH  = 4,
  parameter int unsigned PE_LAT       = DefaultPeLat
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] ifm_len,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  conv_seq_ctrl_if.master        bus
);

  localparam int unsigned WgtRowWidth = WEIGHT_WIDTH * KERNEL_SIZE;
  localparam logic [INDEX_WIDTH-1:0] KLast     = INDEX_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [INDEX_WIDTH-1:0] DrainLast = INDEX_WIDTH'(PE_LAT - 1);

  ctrl_state_t state_q, state_d;
  logic [INDEX_WIDTH-1:0] len_q, len_d;
  logic                   err_q, err_d;
  logic                   set_wgt_q, set_wgt_d;
  logic                   set_ifm_q, set_ifm_d;
  logic [PE_LAT-1:0]      vpipe_q, vpipe_d;
  logic [DATA_WIDTH-1:0]  out_hold_q, out_hold_d;

  logic                   cnt_load, cnt_en, cnt_tc;
  logic [INDEX_WIDTH-1:0] cnt_val, cnt;
  logic                   len_ok;
  logic                   wgt_re_c, ifm_re_c, rd_en_c;
  logic [WgtRowWidth-1:0] wgt_row;
  logic [IFM_WIDTH-1:0]   ifm_pix;

  // One counter times every phase; each phase reloads it on exit of the previous one.
  seq_cnt #(
    .Width(INDEX_WIDTH)
  ) u_phase_cnt (
    .clk_i      (clk1),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .count_o    (cnt),
    .tc_o       (cnt_tc)
  );

  assign len_ok = (32'(ifm_len) >= KERNEL_SIZE) && (32'(ifm_len) <= FIFO_SIZE);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (len_ok) begin
            state_d  = StLdWgt;
            len_d    = ifm_len;
            err_d    = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = KLast;
          end else begin
            state_d = StFin;
            err_d   = 1'b1;
          end
        end
      end
      StLdWgt: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = StLdIfm;
          cnt_load = 1'b1;
          cnt_val  = len_q;
        end
      end
      StLdIfm: begin
        // N reads plus one cycle for the last pixel to land in the FIFO.
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = StCompute;
          cnt_load = 1'b1;
          cnt_val  = INDEX_WIDTH'(n_out(32'(len_q), KERNEL_SIZE) - 1);
        end
      end
      StCompute: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d  = StDrain;
          cnt_load = 1'b1;
          cnt_val  = DrainLast;
        end
      end
      StDrain: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    wgt_re_c   = (state_q == StLdWgt);
    ifm_re_c   = (state_q == StLdIfm) && !cnt_tc;
    rd_en_c    = (state_q == StCompute);
    set_wgt_d  = wgt_re_c;
    set_ifm_d  = ifm_re_c;
    vpipe_d    = (vpipe_q << 1) | PE_LAT'(rd_en_c);
    out_valid  = vpipe_q[PE_LAT-1];
    out_data   = out_valid ? bus.data_output : out_hold_q;
    out_hold_d = out_data;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      err_q      <= 1'b0;
      set_wgt_q  <= 1'b0;
      set_ifm_q  <= 1'b0;
      vpipe_q    <= '0;
      out_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      err_q      <= err_d;
      set_wgt_q  <= set_wgt_d;
      set_ifm_q  <= set_ifm_d;
      vpipe_q    <= vpipe_d;
      out_hold_q <= out_hold_d;
    end
  end

  // Buffer data arrives one cycle after the read, in step with the strobe flops.
  assign wgt_row      = bus.wgt_rdata;
  assign ifm_pix      = bus.ifm_rdata;
  assign bus.wgt_re   = wgt_re_c;
  assign bus.wgt_addr = wgt_re_c ? (KLast - cnt) : '0;
  assign bus.ifm_re   = ifm_re_c;
  assign bus.ifm_addr = ifm_re_c ? (len_q - cnt) : '0;
  assign bus.set_wgt  = set_wgt_q;
  assign bus.wgt      = set_wgt_q ? wgt_row : '0;
  assign bus.set_ifm  = set_ifm_q;
  assign bus.wr_en    = set_ifm_q;
  assign bus.ifm      = set_ifm_q ? ifm_pix : '0;
  assign bus.rd_en    = rd_en_c;
  assign busy         = (state_q != StIdle);
  assign bus.set_reg  = busy;
  assign done         = (state_q == StFin);
  assign err          = err_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: expected timing derived from the job start cycle and row length.
module tb_conv_seq_ctrl;

  localparam int unsigned K  = 3;
  localparam int unsigned FS = 10;
  localparam int unsigned P  = 2;
  localparam int unsigned IW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned WW = 8;
  localparam int unsigned XW = 8;
  localparam int unsigned WR = WW * K;

  logic          clk1 = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] ifm_len = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, done, err;

  conv_seq_ctrl_if #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .IFM_WIDTH(XW), .KERNEL_SIZE(K), .INDEX_WIDTH(IW)
  ) bus ();

  conv_seq_ctrl #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .IFM_WIDTH(XW), .KERNEL_SIZE(K),
    .FIFO_SIZE(FS), .INDEX_WIDTH(IW), .PE_LAT(P)
  ) dut (
    .clk1      (clk1),
    .rst       (rst),
    .start     (start),
    .ifm_len   (ifm_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus)
  );

  always #5 clk1 = ~clk1;

  logic [WR-1:0] wmem [16];
  logic [XW-1:0] imem [16];

  // Synchronous-read buffers; rdata is junk in cycles that follow no read.
  always @(posedge clk1) begin
    bus.wgt_rdata <= bus.wgt_re ? wmem[bus.wgt_addr] : WR'($urandom);
    bus.ifm_rdata <= bus.ifm_re ? imem[bus.ifm_addr] : XW'($urandom);
  end

  int            n_assert = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            chk_en = 1'b0;
  bit            job_valid = 1'b0;
  bit            jrej = 1'b0;
  int            t0 = 0;
  int            jn = 0;
  int            jd = 0;
  bit            err_exp = 1'b0;
  int            n_accept = 0;
  int            ov_cnt = 0;
  int            wr_cnt = 0;
  logic [DW-1:0] dout_cur = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit model_idle();
    return !job_valid || (cyc > t0 + jd);
  endfunction

  task automatic check_cycle();
    int r, m, ewa, eia;
    bit ewr, esw, eir, esi, erd, eov, ebusy, edone;
    logic [10:0] e, o;
    r = cyc - t0;
    m = jn - int'(K) + 1;
    {ewr, esw, eir, esi, erd, eov, ebusy, edone} = '0;
    ewa = 0;
    eia = 0;
    if (job_valid && jrej) begin
      ebusy = (r == 1);
      edone = (r == 1);
    end else if (job_valid) begin
      ewr   = (r >= 1) && (r <= int'(K));
      esw   = (r >= 2) && (r <= int'(K) + 1);
      eir   = (r >= int'(K) + 1) && (r <= int'(K) + jn);
      esi   = (r >= int'(K) + 2) && (r <= int'(K) + jn + 1);
      erd   = (r >= int'(K) + jn + 2) && (r <= int'(K) + jn + 1 + m);
      eov   = (r >= int'(K) + jn + 2 + int'(P)) && (r <= int'(K) + jn + 1 + m + int'(P));
      ebusy = (r >= 1) && (r <= jd);
      edone = (r == jd);
      if (ewr) ewa = r - 1;
      if (eir) eia = r - int'(K) - 1;
    end
    e = {ewr, esw, eir, esi, esi, erd, eov, ebusy, ebusy, edone, err_exp};
    o = {bus.wgt_re, bus.set_wgt, bus.ifm_re, bus.set_ifm, bus.wr_en, bus.rd_en,
         out_valid, busy, bus.set_reg, done, err};
    check("strobes{wre,swgt,ire,sifm,wr,rd,ov,busy,sreg,done,err}", 32'(o), 32'(e));
    check("wgt_addr", 32'(bus.wgt_addr), ewa);
    check("ifm_addr", 32'(bus.ifm_addr), eia);
    if (esw) check("wgt_row", 32'(bus.wgt), 32'(wmem[r - 2]));
    if (esi) check("ifm_pixel", 32'(bus.ifm), 32'(imem[r - int'(K) - 2]));
    if (eov) check("out_data", 32'(out_data), 32'(dout_cur));
    ov_cnt += int'(out_valid);
    wr_cnt += int'(bus.wr_en);
  endtask

  // Check the current cycle, then drive this cycle's inputs and advance the model.
  task automatic tick(input bit st, input int len, input bit rs);
    logic [DW-1:0] d;
    @(negedge clk1);
    if (chk_en) check_cycle();
    rst     = rs;
    start   = st;
    ifm_len = IW'(len);
    d = DW'($urandom);
    bus.data_output = d;
    dout_cur = d;
    if (rs) begin
      job_valid = 1'b0;
      err_exp   = 1'b0;
    end else if (st && model_idle()) begin
      t0        = cyc;
      jn        = len;
      jrej      = (len < int'(K)) || (len > int'(FS));
      jd        = jrej ? 1 : int'(K) + jn + 2 + (jn - int'(K) + 1) + int'(P);
      job_valid = 1'b1;
      err_exp   = jrej;
      n_accept++;
    end
    cyc++;
    chk_en = 1'b1;
  endtask

  task automatic run_job(input int len, input bit noisy);
    ov_cnt = 0;
    wr_cnt = 0;
    tick(1'b1, len, 1'b0);
    for (int i = 0; i < 100 && !model_idle(); i++) begin
      tick(noisy && ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)), 1'b0);
    end
    check("n_results", ov_cnt, jrej ? 0 : jn - int'(K) + 1);
    check("n_wr_en", wr_cnt, jrej ? 0 : jn);
  endtask

  initial begin
    int acc0;
    for (int i = 0; i < 16; i++) begin
      wmem[i] = WR'($urandom);
      imem[i] = XW'($urandom);
    end
    wmem[0] = 24'h010101;
    wmem[1] = 24'h020102;
    wmem[2] = 24'h030401;
    imem[0] = 8'd1;
    for (int i = 1; i < 7; i++) imem[i] = 8'd2;

    repeat (3) tick(1'b0, 0, 1'b1);
    repeat (2) tick(1'b0, 0, 1'b0);

    // Nominal job with stray start pulses while busy.
    run_job(7, 1'b1);
    repeat (2) tick(1'b0, 0, 1'b0);

    // Rejected lengths, then a minimal valid job.
    run_job(2, 1'b0);
    tick(1'b0, 0, 1'b0);
    run_job(11, 1'b0);
    tick(1'b0, 0, 1'b0);
    run_job(3, 1'b0);
    tick(1'b0, 0, 1'b0);

    // Start held high: second job accepted the cycle after the first done.
    acc0 = n_accept;
    for (int i = 0; i < 200; i++) begin
      if ((n_accept - acc0 >= 2) && model_idle()) break;
      tick(1'b1, (n_accept - acc0 == 0) ? 5 : 4, 1'b0);
    end
    repeat (2) tick(1'b0, 0, 1'b0);

    // Reset in the middle of COMPUTE.
    tick(1'b1, 7, 1'b0);
    repeat (12) tick(1'b0, 0, 1'b0);
    tick(1'b0, 0, 1'b1);
    repeat (2) tick(1'b0, 0, 1'b0);
    run_job(7, 1'b0);
    tick(1'b0, 0, 1'b0);

    // Length boundaries.
    run_job(3, 1'b0);
    run_job(10, 1'b0);
    run_job(0, 1'b0);
    run_job(15, 1'b0);
    tick(1'b0, 0, 1'b0);

    // Random jobs with random buffer contents and gaps.
    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 16; i++) begin
        wmem[i] = WR'($urandom);
        imem[i] = XW'($urandom);
      end
      repeat ($urandom_range(0, 3)) tick(1'b0, 0, 1'b0);
      run_job(int'($urandom_range(0, 15)), 1'b1);
    end
    repeat (3) tick(1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
